// File: rtl/max_pool_pkg.sv
// max_pool_pkg: shared compare-mode constants and index-width helper for max_pool_stream.
package max_pool_pkg;

   localparam int CMP_UNSIGNED = 0;
   localparam int CMP_SIGNED   = 1;

   // Width of an argmax index for an n-element window, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/max_pool_stream_if.sv
// max_pool_stream_if: input and result stream handshakes of max_pool_stream.
// out_idx exists only when MAX_POOL_ARGMAX_EN is defined.
interface max_pool_stream_if #(
   parameter int IN_D_W = 8,
`ifdef MAX_POOL_ARGMAX_EN
   parameter int IDX_W = 1,
`endif
   parameter int CH = 1
);

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_D_W*CH-1:0] in_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [IN_D_W*CH-1:0] out_data;
`ifdef MAX_POOL_ARGMAX_EN
   logic [IDX_W*CH-1:0]  out_idx;
`endif

   modport master (
`ifdef MAX_POOL_ARGMAX_EN
      input  out_idx,
`endif
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
`ifdef MAX_POOL_ARGMAX_EN
      output out_idx,
`endif
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/max_lane.sv
// max_lane: one channel's running maximum (and argmax with MAX_POOL_ARGMAX_EN) over a window.
// nxt_acc/nxt_idx expose the value including the current beat so the closing beat can be captured.
module max_lane
   import max_pool_pkg::*;
#(
   parameter int IN_D_W = 8,
`ifdef MAX_POOL_ARGMAX_EN
   parameter int IDX_W  = 1,
`endif
   parameter int SIGNED = CMP_UNSIGNED
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              first,
`ifdef MAX_POOL_ARGMAX_EN
   input  logic [IDX_W-1:0]  cnt,
   output logic [IDX_W-1:0]  nxt_idx,
`endif
   input  logic [IN_D_W-1:0] din,
   output logic [IN_D_W-1:0] nxt_acc
);

   logic [IN_D_W-1:0] acc_q;
   logic              gt;
   logic              take;

   generate
      if (SIGNED == CMP_SIGNED) begin : g_signed
         assign gt = $signed(din) > $signed(acc_q);
      end else begin : g_unsigned
         assign gt = din > acc_q;
      end
   endgenerate

   // Strictly greater only: a tie keeps the earlier element and its position.
   assign take    = first || gt;
   assign nxt_acc = take ? din : acc_q;

`ifdef MAX_POOL_ARGMAX_EN
   logic [IDX_W-1:0] idx_q;

   assign nxt_idx = take ? cnt : idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q <= '0;
      end else if (load) begin
         idx_q <= nxt_idx;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else if (load) begin
         acc_q <= nxt_acc;
      end
   end

endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: serial-input R x C max pooling over CH parallel lanes, one result per N beats.
// Define MAX_POOL_ARGMAX_EN to track the per-lane argmax and drive it on bus.out_idx.
module max_pool_stream
   import max_pool_pkg::*;
#(
   parameter int IN_D_W = 8,
   parameter int R      = 3,
   parameter int C      = 3,
   parameter int CH     = 1,
   parameter int SIGNED = CMP_UNSIGNED
) (
   input logic              clk,
   input logic              rst,
   max_pool_stream_if.slave bus
);

   localparam int               N     = R * C;
   localparam int               IDX_W = idx_width(N);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

   logic [IDX_W-1:0]     cnt_q;
   logic                 out_valid_q;
   logic [IN_D_W*CH-1:0] out_data_q;
   logic [IN_D_W*CH-1:0] nxt_data;
   logic                 last;
   logic                 first;
   logic                 in_ready;
   logic                 accept;
   logic                 consume;

   assign last  = (cnt_q == LAST);
   assign first = (cnt_q == '0);

   // Only the closing beat needs a free output register; partial windows keep accumulating.
   assign in_ready = !(last && out_valid_q && !bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign consume  = out_valid_q && bus.out_ready;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

`ifdef MAX_POOL_ARGMAX_EN
   logic [IDX_W*CH-1:0] out_idx_q;
   logic [IDX_W*CH-1:0] nxt_idx;

   assign bus.out_idx = out_idx_q;
`endif

   generate
      for (genvar k = 0; k < CH; k++) begin : g_lane
         max_lane #(
            .IN_D_W (IN_D_W),
`ifdef MAX_POOL_ARGMAX_EN
            .IDX_W  (IDX_W),
`endif
            .SIGNED (SIGNED)
         ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (accept),
            .first   (first),
`ifdef MAX_POOL_ARGMAX_EN
            .cnt     (cnt_q),
            .nxt_idx (nxt_idx[k*IDX_W +: IDX_W]),
`endif
            .din     (bus.in_data[k*IN_D_W +: IN_D_W]),
            .nxt_acc (nxt_data[k*IN_D_W +: IN_D_W])
         );
      end
   endgenerate

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef MAX_POOL_ARGMAX_EN
         out_idx_q   <= '0;
`endif
      end else begin
         if (accept) begin
            cnt_q <= last ? '0 : cnt_q + IDX_W'(1);
         end
         if (accept && last) begin
            out_valid_q <= 1'b1;
            out_data_q  <= nxt_data;
`ifdef MAX_POOL_ARGMAX_EN
            out_idx_q   <= nxt_idx;
`endif
         end else if (consume) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: random and directed checks of max_pool_stream against a window-level model.
// Instances: A (CH=4, 3x3, unsigned), B (1 lane, 2x2, signed), D (1 lane, 2x2, unsigned), C (2 lanes, 1x1).
module tb_max_pool_stream;
   import max_pool_pkg::*;

   localparam int W    = 8;
   localparam int A_CH = 4;
   localparam int A_N  = 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   max_pool_stream_if #(
      .IN_D_W (W),
`ifdef MAX_POOL_ARGMAX_EN
      .IDX_W  (4),
`endif
      .CH     (A_CH)
   ) a_bus ();

   max_pool_stream_if #(
      .IN_D_W (W),
`ifdef MAX_POOL_ARGMAX_EN
      .IDX_W  (2),
`endif
      .CH     (1)
   ) b_bus ();

   max_pool_stream_if #(
      .IN_D_W (W),
`ifdef MAX_POOL_ARGMAX_EN
      .IDX_W  (2),
`endif
      .CH     (1)
   ) d_bus ();

   max_pool_stream_if #(
      .IN_D_W (W),
`ifdef MAX_POOL_ARGMAX_EN
      .IDX_W  (1),
`endif
      .CH     (2)
   ) c_bus ();

   max_pool_stream #(.IN_D_W(W), .R(3), .C(3), .CH(A_CH), .SIGNED(CMP_UNSIGNED))
      u_a (.clk(clk), .rst(rst), .bus(a_bus));
   max_pool_stream #(.IN_D_W(W), .R(2), .C(2), .CH(1), .SIGNED(CMP_SIGNED))
      u_b (.clk(clk), .rst(rst), .bus(b_bus));
   max_pool_stream #(.IN_D_W(W), .R(2), .C(2), .CH(1), .SIGNED(CMP_UNSIGNED))
      u_d (.clk(clk), .rst(rst), .bus(d_bus));
   max_pool_stream #(.IN_D_W(W), .R(1), .C(1), .CH(2), .SIGNED(CMP_UNSIGNED))
      u_c (.clk(clk), .rst(rst), .bus(c_bus));

   // Window-level model of instance A: collect accepted beats, take the max when the window fills.
   int           a_cnt       = 0;
   bit           a_exp_valid = 1'b0;
   logic [W-1:0] a_win      [A_CH][A_N];
   logic [W-1:0] a_exp_data [A_CH];
   int           a_exp_idx  [A_CH];
   int           a_results   = 0;
   bit           a_took;

   always @(negedge clk) begin : a_model
      bit           exp_ready;
      bit           took;
      logic [W-1:0] best;
      int           bi;
      exp_ready = !(a_cnt == A_N - 1 && a_exp_valid && !a_bus.out_ready);
      check("a_in_ready", a_bus.in_ready, exp_ready);
      check("a_out_valid", a_bus.out_valid, a_exp_valid);
      if (a_exp_valid) begin
         for (int k = 0; k < A_CH; k++) begin
            check("a_out_data", a_bus.out_data[k*W +: W], a_exp_data[k]);
`ifdef MAX_POOL_ARGMAX_EN
            check("a_out_idx", a_bus.out_idx[k*4 +: 4], a_exp_idx[k]);
`endif
         end
      end
      if (a_bus.out_valid && a_bus.out_ready) a_results++;
      if (rst) begin
         a_cnt       = 0;
         a_exp_valid = 1'b0;
      end else begin
         took = a_bus.in_valid && exp_ready;
         if (took) begin
            for (int k = 0; k < A_CH; k++) a_win[k][a_cnt] = a_bus.in_data[k*W +: W];
         end
         if (took && a_cnt == A_N - 1) begin
            for (int k = 0; k < A_CH; k++) begin
               best = a_win[k][0];
               bi   = 0;
               for (int j = 1; j < A_N; j++) begin
                  if (a_win[k][j] > best) begin
                     best = a_win[k][j];
                     bi   = j;
                  end
               end
               a_exp_data[k] = best;
               a_exp_idx[k]  = bi;
            end
            a_exp_valid = 1'b1;
            a_cnt       = 0;
         end else begin
            if (took) a_cnt++;
            if (a_exp_valid && a_bus.out_ready) a_exp_valid = 1'b0;
         end
      end
   end

   task automatic a_cycle(input bit v, input bit ordy, input logic [31:0] d);
      a_bus.in_valid  = v;
      a_bus.out_ready = ordy;
      a_bus.in_data   = d;
      @(negedge clk);
      a_took = a_bus.in_valid && a_bus.in_ready;
      @(posedge clk);
      #1;
   endtask

   int           lit [9] = '{3, 7, 1, 9, 9, 2, 0, 5, 4};
   logic [W-1:0] bd  [4] = '{8'hF0, 8'h80, 8'h05, 8'hFF};
   logic [15:0]  cv;
   logic [31:0]  hold;
   int           r0;
   int           took_cnt;
   logic [7:0]   bj;

   initial begin
      a_bus.in_valid = 1'b0; a_bus.in_data = '0; a_bus.out_ready = 1'b1;
      b_bus.in_valid = 1'b0; b_bus.in_data = '0; b_bus.out_ready = 1'b1;
      d_bus.in_valid = 1'b0; d_bus.in_data = '0; d_bus.out_ready = 1'b1;
      c_bus.in_valid = 1'b0; c_bus.in_data = '0; c_bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_valid", a_bus.out_valid, 1'b0);
      check("rst_a_data", a_bus.out_data, 32'h0);
      check("rst_a_ready", a_bus.in_ready, 1'b1);
      rst = 1'b0;

      // Signed versus unsigned compare on the same 2x2 stream.
      for (int i = 0; i < 4; i++) begin
         b_bus.in_valid = 1'b1; b_bus.in_data = bd[i];
         d_bus.in_valid = 1'b1; d_bus.in_data = bd[i];
         @(posedge clk);
         #1;
      end
      b_bus.in_valid = 1'b0;
      d_bus.in_valid = 1'b0;
      check("b_signed_valid", b_bus.out_valid, 1'b1);
      check("b_signed_data", b_bus.out_data, 8'h05);
      check("d_unsigned_valid", d_bus.out_valid, 1'b1);
      check("d_unsigned_data", d_bus.out_data, 8'hFF);
`ifdef MAX_POOL_ARGMAX_EN
      check("b_signed_idx", b_bus.out_idx, 2'd2);
      check("d_unsigned_idx", d_bus.out_idx, 2'd3);
`endif

      // Window of one: each beat appears on the output the next cycle.
      for (int i = 0; i < 12; i++) begin
         cv = 16'($urandom);
         c_bus.in_valid = 1'b1;
         c_bus.in_data  = cv;
         @(posedge clk);
         #1;
         check("c_pass_valid", c_bus.out_valid, 1'b1);
         check("c_pass_data", c_bus.out_data, cv);
`ifdef MAX_POOL_ARGMAX_EN
         check("c_pass_idx", c_bus.out_idx, 2'd0);
`endif
      end
      c_bus.in_valid = 1'b0;

      // Lane 0 directed window: the tie on 9 keeps the first position.
      for (int i = 0; i < 9; i++) a_cycle(1'b1, 1'b1, {24'($urandom), 8'(lit[i])});
      a_bus.in_valid = 1'b0;
      check("a_lit_valid", a_bus.out_valid, 1'b1);
      check("a_lit_data", a_bus.out_data[7:0], 8'd9);
`ifdef MAX_POOL_ARGMAX_EN
      check("a_lit_idx", a_bus.out_idx[3:0], 4'd3);
`endif
      a_cycle(1'b0, 1'b1, '0);
      a_cycle(1'b0, 1'b1, '0);

      // Back-to-back windows: every beat accepted, one result per nine beats.
      r0       = a_results;
      took_cnt = 0;
      for (int i = 0; i < 90; i++) begin
         a_cycle(1'b1, 1'b1, $urandom);
         if (a_took) took_cnt++;
      end
      a_cycle(1'b0, 1'b1, '0);
      a_cycle(1'b0, 1'b1, '0);
      check("a_stream_accepts", took_cnt, 90);
      check("a_stream_results", a_results - r0, 10);

      // Downstream stall: only the closing beat of the next window waits.
      for (int i = 0; i < 9; i++) a_cycle(1'b1, 1'b1, $urandom);
      hold = a_bus.out_data;
      for (int i = 0; i < 20; i++) a_cycle(1'b1, 1'b0, $urandom);
      check("a_stall_ready", a_bus.in_ready, 1'b0);
      check("a_stall_hold", a_bus.out_data, hold);
      a_cycle(1'b1, 1'b1, $urandom);
      check("a_stall_close_took", a_took, 1'b1);
      check("a_stall_new_valid", a_bus.out_valid, 1'b1);
      a_cycle(1'b0, 1'b1, '0);
      a_cycle(1'b0, 1'b1, '0);

      // Reset after five large beats: the next window must not see them.
      for (int i = 0; i < 5; i++) a_cycle(1'b1, 1'b1, 32'hC8C8_C8C8);
      a_bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("a_midrst_valid", a_bus.out_valid, 1'b0);
      check("a_midrst_data", a_bus.out_data, 32'h0);
      check("a_midrst_ready", a_bus.in_ready, 1'b1);
      for (int j = 0; j < 9; j++) begin
         bj = 8'(j * 5);
         a_cycle(1'b1, 1'b1, {4{bj}});
      end
      a_bus.in_valid = 1'b0;
      check("a_clean_valid", a_bus.out_valid, 1'b1);
      check("a_clean_data", a_bus.out_data, 32'h2828_2828);
`ifdef MAX_POOL_ARGMAX_EN
      check("a_clean_idx", a_bus.out_idx, 16'h8888);
`endif

      // Random valid/ready traffic, checked every cycle by the model.
      for (int i = 0; i < 3000; i++) begin
         a_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom);
      end
      for (int i = 0; i < 3; i++) a_cycle(1'b0, 1'b1, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
